// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, transmitter state encoding
// and the default baud divisor (50 MHz system clock, 115.2 kbaud).
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam int unsigned UART_DIV_115200_50M = 434;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready byte stream into the UART transmitter.
//   in_data  : word to queue
//   in_valid : in_data is valid this cycle
//   in_ready : transmitter FIFO can accept a word (not full)
interface uart_tx_stream_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO. Full/empty are decided by the word count;
// pointers wrap naturally because DEPTH is a power of two. Storage is not
// reset: clearing the count is enough to discard queued words.
//   clock_50M, rst : clock, async active-high reset
//   push, wr_data  : write request (ignored while full)
//   pop, rd_data_c : read request (ignored while empty), head word
//   full_c, empty_c, count : occupancy
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clock_50M,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full_c    = (count == CNT_W'(DEPTH));
   assign empty_c   = (count == '0);
   assign rd_data_c = mem[rd_ptr];
   assign push_ok   = push && !full_c;
   assign pop_ok    = pop && !empty_c;

   // Pointer and occupancy tracking
   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write
   always_ff @(posedge clock_50M) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter with built-in transmit FIFO and valid/ready input.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS
// stop(1); every bit lasts CLK_DIV clocks. Back-to-back frames have no gap.
// Optional build macro UART_TX_CTS_EN adds an active-low clear-to-send input
// that gates the start of each frame (never truncates a running one).
//   clock_50M, rst : clock, async active-high reset
//   stream         : valid/ready input (in_data, in_valid, in_ready)
//   tx             : serial line, idles high
//   busy           : a frame is on the line
//   fifo_count     : words queued
//   cts_n          : clear-to-send, active-low (UART_TX_CTS_EN only)
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = UART_DIV_115200_50M,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = PARITY_NONE,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clock_50M,
   input  logic                        rst,
   uart_tx_stream_if.slave             stream,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_TX_CTS_EN
   ,
   input  logic                        cts_n
`endif
);
   // Elaboration-time parameter legality
   if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
      $error("uart_tx_stream: CLK_DIV out of range 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $error("uart_tx_stream: DATA_BITS out of range 5..8");
   end
   if (PARITY > PARITY_ODD) begin : g_bad_par
      $error("uart_tx_stream: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_stream: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [DATA_BITS-1:0] head_c;
   logic                 full_c;
   logic                 empty_c;
   logic                 pop_c;
   logic                 clear_c;
   logic                 start_ok_c;
   logic                 last_c;

   tx_state_e            state_q, state_n;
   logic [15:0]          cnt_q, cnt_n;
   logic [2:0]           bit_q, bit_n;
   logic [DATA_BITS-1:0] sh_q, sh_n;
   logic                 par_q, par_n;
   logic                 tx_n;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock_50M (clock_50M),
      .rst       (rst),
      .push      (stream.in_valid),
      .wr_data   (stream.in_data),
      .pop       (pop_c),
      .rd_data_c (head_c),
      .full_c    (full_c),
      .empty_c   (empty_c),
      .count     (fifo_count)
   );

   assign stream.in_ready = !full_c;
   assign busy            = (state_q != ST_IDLE);

`ifdef UART_TX_CTS_EN
   // Two-flop synchroniser; resets to "not clear"
   logic cts_meta_q;
   logic cts_sync_q;
   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst) begin
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         cts_meta_q <= cts_n;
         cts_sync_q <= cts_meta_q;
      end
   end
   assign clear_c = !cts_sync_q;
`else
   assign clear_c = 1'b1;
`endif

   assign start_ok_c = !empty_c && clear_c;
   assign last_c     = (cnt_q == 16'(CLK_DIV - 1));

   // Serialiser state register
   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         sh_q    <= sh_n;
         par_q   <= par_n;
         tx      <= tx_n;
      end
   end

   // Serialiser next-state and line value
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q + 16'd1;
      bit_n   = bit_q;
      sh_n    = sh_q;
      par_n   = par_q;
      tx_n    = tx;
      pop_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
            if (start_ok_c) pop_c = 1'b1;
         end
         ST_START: begin
            if (last_c) begin
               state_n = ST_DATA;
               cnt_n   = '0;
               bit_n   = '0;
               tx_n    = sh_q[0];
            end
         end
         ST_DATA: begin
            if (last_c) begin
               cnt_n = '0;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  bit_n = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_n = ST_PAR;
                     tx_n    = par_q;
                  end else begin
                     state_n = ST_STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n = bit_q + 3'd1;
                  sh_n  = sh_q >> 1;
                  tx_n  = sh_n[0];
               end
            end
         end
         ST_PAR: begin
            if (last_c) begin
               state_n = ST_STOP;
               cnt_n   = '0;
               bit_n   = '0;
               tx_n    = 1'b1;
            end
         end
         ST_STOP: begin
            if (last_c) begin
               cnt_n = '0;
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  if (start_ok_c) begin
                     pop_c = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
         end
      endcase

      // Launch a frame from the FIFO head (from IDLE or straight out of STOP)
      if (pop_c) begin
         state_n = ST_START;
         cnt_n   = '0;
         bit_n   = '0;
         sh_n    = head_c;
         par_n   = (^head_c) ^ (PARITY == PARITY_ODD);
         tx_n    = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
`timescale 1ns/1ps
module tb_uart_tx_stream;
   import uart_pkg::*;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       vld [2];
   int         dat [2];
   logic       tx0, tx1, busy0, busy1;
   logic [2:0] cnt0, cnt1;
`ifdef UART_TX_CTS_EN
   logic cts_n;
   logic cs1, cs2;
`endif

   uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
   uart_tx_stream_if #(.DATA_BITS(7)) if1 ();
   assign if0.in_valid = vld[0];
   assign if0.in_data  = 8'(dat[0]);
   assign if1.in_valid = vld[1];
   assign if1.in_data  = 7'(dat[1]);

   // Instance 0: 8N1; instance 1: 7 data bits, odd parity, 2 stop bits
   uart_tx_stream #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(PARITY_NONE),
                    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
      .clock_50M(clk), .rst(rst), .stream(if0), .tx(tx0), .busy(busy0),
      .fifo_count(cnt0)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );
   uart_tx_stream #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(PARITY_ODD),
                    .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clock_50M(clk), .rst(rst), .stream(if1), .tx(tx1), .busy(busy1),
      .fifo_count(cnt1)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );

   logic       tx_o   [2];
   logic       busy_o [2];
   logic       rdy_o  [2];
   logic [2:0] cnt_o  [2];
   assign tx_o[0] = tx0;   assign tx_o[1] = tx1;
   assign busy_o[0] = busy0; assign busy_o[1] = busy1;
   assign cnt_o[0] = cnt0; assign cnt_o[1] = cnt1;
   assign rdy_o[0] = if0.in_ready; assign rdy_o[1] = if1.in_ready;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic int db(input int i); return (i == 0) ? 8 : 7; endfunction
   function automatic int pm(input int i); return (i == 0) ? 0 : 2; endfunction
   function automatic int sb(input int i); return (i == 0) ? 1 : 2; endfunction

   // Reference model: queued words and the remaining per-cycle line values
   int fifo_q [2][$];
   bit line_q [2][$];

   task automatic start_frame(input int i, input int w);
      int bits[$];
      int par;
      par = 0;
      bits.push_back(0);
      for (int b = 0; b < db(i); b++) begin
         bits.push_back((w >> b) & 1);
         par ^= (w >> b) & 1;
      end
      if (pm(i) == 1) bits.push_back(par);
      if (pm(i) == 2) bits.push_back(par ^ 1);
      for (int s = 0; s < sb(i); s++) bits.push_back(1);
      foreach (bits[k]) repeat (DIV) line_q[i].push_back(1'(bits[k]));
   endtask

   initial begin : model_and_compare
      bit push_ok;
      bit clr;
      int w;
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < 2; i++) begin
               fifo_q[i].delete();
               line_q[i].delete();
            end
`ifdef UART_TX_CTS_EN
            cs1 = 1'b1;
            cs2 = 1'b1;
`endif
         end else begin
            for (int i = 0; i < 2; i++) begin
`ifdef UART_TX_CTS_EN
               clr = (cs2 == 1'b0);
`else
               clr = 1'b1;
`endif
               push_ok = vld[i] && (fifo_q[i].size() < DEPTH);
               if (line_q[i].size() > 0) void'(line_q[i].pop_front());
               if (line_q[i].size() == 0 && fifo_q[i].size() > 0 && clr) begin
                  w = fifo_q[i].pop_front();
                  start_frame(i, w);
               end
               if (push_ok) fifo_q[i].push_back(dat[i] & ((1 << db(i)) - 1));
            end
`ifdef UART_TX_CTS_EN
            cs2 = cs1;
            cs1 = cts_n;
`endif
         end
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < 2; i++) begin
               check($sformatf("tx[%0d]", i), 32'(tx_o[i]),
                     (line_q[i].size() > 0) ? 32'(line_q[i][0]) : 32'd1);
               check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(line_q[i].size() > 0));
               check($sformatf("fifo_count[%0d]", i), 32'(cnt_o[i]), 32'(fifo_q[i].size()));
               check($sformatf("in_ready[%0d]", i), 32'(rdy_o[i]), 32'(fifo_q[i].size() < DEPTH));
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [9:0]  f0_exp;
      logic [10:0] f1_exp;
      int          words [6];
      int          k;
      int          guard;
      int          accept_edge;
      int          slot;
      logic        acc [2];

      f0_exp = 10'b1010101010;   // start, 0x55 LSB first, stop
      f1_exp = 11'b11100000110;  // start, 0x03 7 bits, odd parity 1, 2 stops
      words  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
      rst = 1'b1;
      vld = '{1'b0, 1'b0};
      dat = '{0, 0};
`ifdef UART_TX_CTS_EN
      cts_n = 1'b0;
`endif
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_tx", 32'(tx_o[i]), 32'd1);
         check("rst_busy", 32'(busy_o[i]), 32'd0);
         check("rst_count", 32'(cnt_o[i]), 32'd0);
         check("rst_ready", 32'(rdy_o[i]), 32'd1);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single frames on both instances, pinned against literal waveforms
      dat = '{32'h55, 32'h03};
      vld = '{1'b1, 1'b1};
      @(negedge clk);
      vld = '{1'b0, 1'b0};
      check("push_count0", 32'(cnt0), 32'd1);
      check("push_count1", 32'(cnt1), 32'd1);
      check("push_tx0_idle", 32'(tx0), 32'd1);
      for (int j = 0; j < 46; j++) begin
         @(negedge clk);
         slot = j / DIV;
         check($sformatf("frame0_c%0d", j), 32'(tx0), (slot < 10) ? 32'(f0_exp[slot]) : 32'd1);
         check($sformatf("frame1_c%0d", j), 32'(tx1), (slot < 11) ? 32'(f1_exp[slot]) : 32'd1);
         if (j == 39) check("busy0_last", 32'(busy0), 32'd1);
         if (j == 40) check("busy0_fall", 32'(busy0), 32'd0);
         if (j == 43) check("busy1_last", 32'(busy1), 32'd1);
         if (j == 44) check("busy1_fall", 32'(busy1), 32'd0);
      end

      // FIFO fill with in_valid held; sixth word waits for the first pop
      k = 0;
      guard = 0;
      accept_edge = -1;
      vld[0] = 1'b1;
      dat[0] = words[0];
      while (k < 6 && guard < 400) begin
         acc[0] = rdy_o[0];
         @(negedge clk);
         guard++;
         if (acc[0]) begin
            k++;
            if (k == 6) accept_edge = guard;
            if (k < 6) dat[0] = words[k];
            else vld[0] = 1'b0;
         end
         if (guard == 2) check("pushpop_count", 32'(cnt0), 32'd1);
         if (guard == 5) begin
            check("full_count", 32'(cnt0), 32'd4);
            check("full_ready", 32'(rdy_o[0]), 32'd0);
         end
         if (guard == 41) check("b2b_stop", 32'(tx0), 32'd1);
         if (guard == 42) check("b2b_start", 32'(tx0), 32'd0);
      end
      check("late_accept_edge", 32'(accept_edge), 32'd43);
      repeat (260) @(negedge clk);
      check("drain_busy", 32'(busy0), 32'd0);
      check("drain_count", 32'(cnt0), 32'd0);

      // Reset mid-frame with words queued
      for (int c = 0; c < 4; c++) begin
         vld = '{1'b1, 1'b1};
         dat = '{32'hA0 + c, 32'h10 + c};
         @(negedge clk);
      end
      vld = '{1'b0, 1'b0};
      repeat (10) @(negedge clk);
      check("pre_rst_count0", 32'(cnt0), 32'd3);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("arst_tx", 32'(tx_o[i]), 32'd1);
         check("arst_busy", 32'(busy_o[i]), 32'd0);
         check("arst_count", 32'(cnt_o[i]), 32'd0);
         check("arst_ready", 32'(rdy_o[i]), 32'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("post_rst_busy0", 32'(busy0), 32'd0);
      check("post_rst_busy1", 32'(busy1), 32'd0);

      // Randomized traffic, checked cycle by cycle against the model
      acc = '{1'b0, 1'b0};
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!vld[i] || acc[i]) begin
               vld[i] = ($urandom_range(0, 99) < ((c < 1500) ? 15 : 4));
               dat[i] = int'($urandom_range(0, 255));
            end
            acc[i] = vld[i] && rdy_o[i];
         end
`ifdef UART_TX_CTS_EN
         if ($urandom_range(0, 63) == 0) cts_n = ~cts_n;
`endif
         @(negedge clk);
      end
      vld = '{1'b0, 1'b0};
`ifdef UART_TX_CTS_EN
      cts_n = 1'b0;
`endif
      repeat (500) @(negedge clk);
      check("final_idle0", 32'(busy0), 32'd0);
      check("final_idle1", 32'(busy1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
